zext_pack_ctrl: RTL and testbench

- Packs a 32-bit valid/ready word stream into 64-bit beats for the 64-bit eBPF datapath and DRAM DMA path.
- In normal mode, two consecutive words form one beat, low word first. A frame with an odd word count ends with a tail beat whose upper half is zero-padded.
- In ZEXT mode, every word is emitted alone as a zero-extended 64-bit beat, as required for ALU32 results.
- Sits between 32-bit producers (CPU register file, ALU32 results) and the 64-bit consumers.

---
 rtl/zext_pack_ctrl.sv | 94 +++++++++
 tb/tb_zext_pack_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zext_pack_ctrl.sv
// Packs a 32-bit word stream into 64-bit beats, low word first, or emits each
// word zero-extended when zext_mode is set at the start of a pair.
module zext_pack_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             zext_mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic [1:0]       m_keep,
    output logic             m_last,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             busy
);

    logic        lo_vld;
    logic [31:0] lo_q;
    logic        mode_q;

    logic out_free;
    logic accept;
    logic handoff;
    logic pair_load;
    logic solo_load;
    logic low_load;

    assign out_free  = !m_valid || m_ready;
    assign s_ready   = out_free;
    assign accept    = s_valid && s_ready;
    assign handoff   = m_valid && m_ready;

    // A pending low word always belongs to a normal-mode pair; the mode
    // sampled when it arrived governs the pair, not the current zext_mode.
    assign pair_load = accept && lo_vld && !mode_q;
    assign solo_load = accept && !lo_vld && (zext_mode || s_last);
    assign low_load  = accept && !lo_vld && !zext_mode && !s_last;

    assign busy = lo_vld || m_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_vld    <= 1'b0;
            lo_q      <= 32'h0;
            mode_q    <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= 64'h0;
            m_keep    <= 2'b00;
            m_last    <= 1'b0;
            frame_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            if (handoff) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                if (m_last) begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end

            // A new beat may load on the same edge the previous one leaves.
            if (pair_load) begin
                m_valid <= 1'b1;
                m_data  <= {s_data, lo_q};
                m_keep  <= 2'b11;
                m_last  <= s_last;
            end else if (solo_load) begin
                m_valid <= 1'b1;
                m_data  <= {32'h0, s_data};
                m_keep  <= 2'b01;
                m_last  <= s_last;
            end else if (handoff) begin
                m_valid <= 1'b0;
            end

            if (accept && !lo_vld) begin
                mode_q <= zext_mode;
            end

            if (low_load) begin
                lo_q   <= s_data;
                lo_vld <= 1'b1;
            end else if (pair_load) begin
                lo_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zext_pack_ctrl.sv
// Scoreboard bench for zext_pack_ctrl: a frame-level model predicts beats,
// a monitor collects output handshakes and compares them in order.
module tb_zext_pack_ctrl;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             zext_mode;
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [63:0]      m_data;
    logic [1:0]       m_keep;
    logic             m_last;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] beat_cnt;
    logic             busy;

    zext_pack_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .zext_mode (zext_mode),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_last    (m_last),
        .frame_cnt (frame_cnt),
        .beat_cnt  (beat_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        last;
        logic [1:0]  keep;
        logic [63:0] data;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t mon_e;
    beat_t mon_g;

    int n_vec      = 0;
    int n_err      = 0;
    int exp_beats  = 0;
    int exp_frames = 0;
    int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: sample handshakes mid-cycle, compare in order against the model.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            got_q.push_back({m_last, m_keep, m_data});
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_g = got_q.pop_front();
            check("beat", 80'(mon_g), 80'(mon_e));
        end
    end

    // Frame-level reference: zext frames are one beat per word; normal frames
    // are word pairs, low first, with a zero-padded tail for odd lengths.
    task automatic model_frame(input logic [31:0] ws[$], input bit zm);
        int n;
        n = ws.size();
        if (zm) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({(i == n - 1), 2'b01, 32'h0, ws[i]});
                exp_beats++;
            end
        end else begin
            for (int i = 0; i < n; i += 2) begin
                if (i + 1 < n) exp_q.push_back({(i + 2 >= n), 2'b11, ws[i+1], ws[i]});
                else           exp_q.push_back({1'b1, 2'b01, 32'h0, ws[i]});
                exp_beats++;
            end
        end
        exp_frames++;
    endtask

    task automatic send_word(input logic [31:0] w, input logic zm, input logic last);
        int waited;
        s_valid   = 1'b1;
        s_data    = w;
        s_last    = last;
        zext_mode = zm;
        waited    = 0;
        forever begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            waited++;
            if (waited > 1000) begin
                $display("FAIL send_word: s_ready stuck low, got 0 expected 1");
                $fatal(1, "input stalled");
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // In normal frames the high-word positions drive a random zext_mode,
    // which must be ignored while a low word is pending.
    task automatic send_frame(input logic [31:0] ws[$], input bit zm, input bit gaps,
                              input bit with_last);
        int n;
        n = ws.size();
        for (int i = 0; i < n; i++) begin
            send_word(ws[i], zm ? 1'b1 : ((i % 2 == 1) ? 1'($urandom_range(0, 1)) : 1'b0),
                      with_last && (i == n - 1));
            if (gaps && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        zext_mode = 1'b0;
        if (with_last) model_frame(ws, zm);
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while ((exp_q.size() > 0 || got_q.size() > 0 || busy) && waited < 2000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check({name, "_drain_timeout"}, 80'(waited < 2000), 80'(1));
        check({name, "_beat_cnt"}, 80'(beat_cnt), 80'(exp_beats % (1 << CNT_W)));
        check({name, "_frame_cnt"}, 80'(frame_cnt), 80'(exp_frames % (1 << CNT_W)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        exp_beats  = 0;
        exp_frames = 0;
    endtask

    task automatic set_ready(input int mode);
        ready_mode = mode;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] wq[$];
    logic [63:0] held;
    int          total;
    int          n;

    initial begin
        rst       = 1'b1;
        zext_mode = 1'b0;
        s_valid   = 1'b0;
        s_data    = 32'h0;
        s_last    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Reset then idle
        check("rst_m_valid", 80'(m_valid), 80'(0));
        check("rst_m_data", 80'(m_data), 80'(0));
        check("rst_m_keep", 80'(m_keep), 80'(0));
        check("rst_m_last", 80'(m_last), 80'(0));
        check("rst_frame_cnt", 80'(frame_cnt), 80'(0));
        check("rst_beat_cnt", 80'(beat_cnt), 80'(0));
        check("rst_busy", 80'(busy), 80'(0));
        check("rst_s_ready", 80'(s_ready), 80'(1));

        set_ready(0);
        wq = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        send_frame(wq, 1'b0, 1'b0, 1'b1);
        drain("even_frame");

        wq = '{32'hA, 32'hB, 32'hC};
        send_frame(wq, 1'b0, 1'b0, 1'b1);
        drain("odd_frame");

        wq = '{32'hFFFFFFFF, 32'h80000000};
        send_frame(wq, 1'b1, 1'b0, 1'b1);
        drain("zext_frame");

        // Backpressure with a beat pending
        set_ready(2);
        wq = '{32'h00001234, 32'h00005678};
        send_frame(wq, 1'b0, 1'b0, 1'b1);
        held = m_data;
        check("bp_data_value", 80'(held), 80'(64'h00005678_00001234));
        for (int i = 0; i < 5; i++) begin
            check("bp_m_valid", 80'(m_valid), 80'(1));
            check("bp_m_data", 80'(m_data), 80'(held));
            check("bp_s_ready", 80'(s_ready), 80'(0));
            @(posedge clk);
            #1;
        end
        set_ready(0);
        drain("bp_release");

        // Random frames under random backpressure, mode changing per frame
        ready_mode = 1;
        total = 0;
        while (total < 64) begin
            n = $urandom_range(1, 7);
            if (n > 64 - total) n = 64 - total;
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            send_frame(wq, ($urandom_range(0, 2) == 0), 1'b1, 1'b1);
            total += n;
        end
        drain("random");

        // Reset with a pending low word
        set_ready(0);
        wq = '{32'h77};
        send_frame(wq, 1'b0, 1'b0, 1'b0);
        check("lo_pending_busy", 80'(busy), 80'(1));
        do_reset();
        check("rst_lo_busy", 80'(busy), 80'(0));
        check("rst_lo_beat_cnt", 80'(beat_cnt), 80'(0));

        // Reset with an undelivered beat
        set_ready(2);
        wq = '{32'h1, 32'h2};
        send_frame(wq, 1'b0, 1'b0, 1'b0);
        check("beat_pending_valid", 80'(m_valid), 80'(1));
        do_reset();
        check("rst_beat_m_valid", 80'(m_valid), 80'(0));
        check("rst_beat_busy", 80'(busy), 80'(0));
        check("rst_beat_frame_cnt", 80'(frame_cnt), 80'(0));
        check("rst_beat_beat_cnt", 80'(beat_cnt), 80'(0));

        set_ready(0);
        wq = '{32'h5};
        send_frame(wq, 1'b0, 1'b0, 1'b1);
        drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
